// File: rtl/wormhole_output_allocator_if.sv
// Handshake bundle between the five input FIFOs and one output-port allocator.
// The pkt_cnt signal exists only when ALLOC_PKT_CNT_EN is defined.
interface wormhole_output_allocator_if #(
  parameter int CW = 3
);
  logic [4:0]    req;
  logic [4:0]    head;
  logic [4:0]    tail;
  logic          credit_in;
  logic [4:0]    grant;
  logic [4:0]    xbar_sel;
  logic          valid_out;
  logic [CW-1:0] credits;
  logic          busy;
  logic          cred_err;
`ifdef ALLOC_PKT_CNT_EN
  logic [15:0]   pkt_cnt;

  modport master (
    output req, head, tail, credit_in,
    input  grant, xbar_sel, valid_out, credits, busy, cred_err, pkt_cnt
  );
  modport slave (
    input  req, head, tail, credit_in,
    output grant, xbar_sel, valid_out, credits, busy, cred_err, pkt_cnt
  );
`else
  modport master (
    output req, head, tail, credit_in,
    input  grant, xbar_sel, valid_out, credits, busy, cred_err
  );
  modport slave (
    input  req, head, tail, credit_in,
    output grant, xbar_sel, valid_out, credits, busy, cred_err
  );
`endif
endinterface

// File: rtl/wormhole_output_allocator.sv
// Round-robin wormhole allocator for one mesh output port with credit flow control.
// Optional completed-packet counter enabled by defining ALLOC_PKT_CNT_EN.
module wormhole_output_allocator #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  wormhole_output_allocator_if.slave   bus
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [2:0]    owner_q, owner_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [4:0]    xbar_sel_q, xbar_sel_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          cred_err_q, cred_err_d;

  logic [4:0]    cand;
  logic [2:0]    pick;
  logic          pick_vld;
  logic [3:0]    scan;
  logic          owner_req;
  logic          owner_tail;
  logic          xfer;
  logic [4:0]    grant_c;
  logic          valid_c;

  assign cand       = bus.req & bus.head;
  assign owner_req  = bus.req[owner_q];
  assign owner_tail = bus.tail[owner_q];
  assign xfer       = (state_q == LOCKED) && owner_req && (credits_q != '0);

  // Scan rr_ptr, rr_ptr+1, ... modulo 5; first candidate wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      scan = {1'b0, rr_ptr_q} + 4'(k);
      if (scan >= 4'd5) scan = scan - 4'd5;
      if (!pick_vld && cand[scan[2:0]]) begin
        pick     = scan[2:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    xbar_sel_d = xbar_sel_q;
    grant_c    = '0;
    valid_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d    = pick;
          xbar_sel_d = 5'(1) << pick;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer) begin
          grant_c = xbar_sel_q;
          valid_c = 1'b1;
          if (owner_tail) begin
            state_d    = IDLE;
            xbar_sel_d = '0;
            rr_ptr_d   = (owner_q == 3'd4) ? 3'd0 : 3'(owner_q + 3'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous return and consume leave the count unchanged.
  always_comb begin
    credits_d  = credits_q;
    cred_err_d = cred_err_q;
    unique case ({xfer, bus.credit_in})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CW'(CREDITS)) cred_err_d = 1'b1;
        else                           credits_d  = credits_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      xbar_sel_q <= '0;
      credits_q  <= CW'(CREDITS);
      cred_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      xbar_sel_q <= xbar_sel_d;
      credits_q  <= credits_d;
      cred_err_q <= cred_err_d;
    end
  end

`ifdef ALLOC_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                    pkt_cnt_q <= '0;
    else if (xfer && owner_tail) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign bus.pkt_cnt = pkt_cnt_q;
`endif

  assign bus.grant     = grant_c;
  assign bus.valid_out = valid_c;
  assign bus.xbar_sel  = xbar_sel_q;
  assign bus.busy      = (state_q == LOCKED);
  assign bus.credits   = credits_q;
  assign bus.cred_err  = cred_err_q;

endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Vector-table bench for wormhole_output_allocator; pkt_cnt checks run when ALLOC_PKT_CNT_EN is defined.
module tb_wormhole_output_allocator;
  localparam int CREDITS = 4;
  localparam int CW      = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wormhole_output_allocator_if #(.CW(CW)) bus ();

  wormhole_output_allocator #(.CREDITS(CREDITS), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic       rst;
    logic [4:0] req;
    logic [4:0] head;
    logic [4:0] tail;
    logic       cin;
    logic       chk;
    logic [4:0] grant;
    logic [4:0] xsel;
    logic       valid;
    logic [2:0] credits;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input string tag, input logic r,
                              input logic [4:0] rq, input logic [4:0] hd, input logic [4:0] tl,
                              input logic ci, input logic ck,
                              input logic [4:0] g, input logic [4:0] xs, input logic vo,
                              input logic [2:0] cr, input logic bz, input logic er);
    vec_t v;
    v.tag = tag; v.rst = r; v.req = rq; v.head = hd; v.tail = tl; v.cin = ci; v.chk = ck;
    v.grant = g; v.xsel = xs; v.valid = vo; v.credits = cr; v.busy = bz; v.err = er;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] hd,
                       input logic [4:0] tl, input logic ci);
    @(posedge clk);
    #1;
    rst           = r;
    bus.req       = rq;
    bus.head      = hd;
    bus.tail      = tl;
    bus.credit_in = ci;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t        e;
    logic [15:0] act;
    logic [15:0] want;
    drive(v.rst, v.req, v.head, v.tail, v.cin);
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.chk) begin
      act  = {bus.grant, bus.xbar_sel, bus.valid_out, bus.credits, bus.busy, bus.cred_err};
      want = {e.grant, e.xsel, e.valid, e.credits, e.busy, e.err};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL %s: got grant=%b xsel=%b valid=%b credits=%0d busy=%b err=%b, expected grant=%b xsel=%b valid=%b credits=%0d busy=%b err=%b",
                 e.tag, bus.grant, bus.xbar_sel, bus.valid_out, bus.credits, bus.busy, bus.cred_err,
                 e.grant, e.xsel, e.valid, e.credits, e.busy, e.err);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  initial begin
    logic [4:0] oh;
    int         waited;
    logic       got;

    rst = 1'b1;
    bus.req = '0; bus.head = '0; bus.tail = '0; bus.credit_in = 1'b0;

    // A: 3-flit packet from North
    add("A_rst",  1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 4, 0, 0);
    add("A_idle", 0, 5'b00010, 5'b00010, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 4, 0, 0);
    add("A_f1",   0, 5'b00010, 5'b00010, 5'b00000, 0, 1, 5'b00010, 5'b00010, 1, 4, 1, 0);
    add("A_f2",   0, 5'b00010, 5'b00000, 5'b00000, 0, 1, 5'b00010, 5'b00010, 1, 3, 1, 0);
    add("A_f3",   0, 5'b00010, 5'b00000, 5'b00010, 0, 1, 5'b00010, 5'b00010, 1, 2, 1, 0);
    add("A_done", 0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 1, 0, 0);

    // B: round-robin over five single-flit streams, credit returned every cycle
    add("B_rst",  1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 4, 0, 0);
    for (int k = 0; k < 6; k++) begin
      oh = 5'b00001 << (k % 5);
      add($sformatf("B_idle%0d", k), 0, 5'b11111, 5'b11111, 5'b11111, 1, 1,
          5'b00000, 5'b00000, 0, 4, 0, (k == 0) ? 1'b0 : 1'b1);
      add($sformatf("B_own%0d", k),  0, 5'b11111, 5'b11111, 5'b11111, 1, 1,
          oh, oh, 1, 4, 1, 1);
    end

    // C: 6-flit packet with credit starvation
    add("C_rst",   1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 4, 0, 0);
    add("C_idle",  0, 5'b00001, 5'b00001, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 4, 0, 0);
    add("C_x1",    0, 5'b00001, 5'b00001, 5'b00000, 0, 1, 5'b00001, 5'b00001, 1, 4, 1, 0);
    add("C_x2",    0, 5'b00001, 5'b00000, 5'b00000, 0, 1, 5'b00001, 5'b00001, 1, 3, 1, 0);
    add("C_x3",    0, 5'b00001, 5'b00000, 5'b00000, 0, 1, 5'b00001, 5'b00001, 1, 2, 1, 0);
    add("C_x4",    0, 5'b00001, 5'b00000, 5'b00000, 0, 1, 5'b00001, 5'b00001, 1, 1, 1, 0);
    add("C_stall0",0, 5'b00001, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00001, 0, 0, 1, 0);
    add("C_stall1",0, 5'b00001, 5'b00000, 5'b00000, 1, 1, 5'b00000, 5'b00001, 0, 0, 1, 0);
    add("C_x5",    0, 5'b00001, 5'b00000, 5'b00000, 0, 1, 5'b00001, 5'b00001, 1, 1, 1, 0);
    add("C_stall2",0, 5'b00001, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00001, 0, 0, 1, 0);
    add("C_stall3",0, 5'b00001, 5'b00000, 5'b00000, 1, 1, 5'b00000, 5'b00001, 0, 0, 1, 0);
    add("C_x6",    0, 5'b00001, 5'b00000, 5'b00001, 0, 1, 5'b00001, 5'b00001, 1, 1, 1, 0);
    add("C_done",  0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0);

    // D: owner 2 underflow bubble while input 0 waits
    add("D_rst",   1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 4, 0, 0);
    add("D_idle",  0, 5'b00100, 5'b00100, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 4, 0, 0);
    add("D_f1",    0, 5'b00100, 5'b00100, 5'b00000, 0, 1, 5'b00100, 5'b00100, 1, 4, 1, 0);
    add("D_bub0",  0, 5'b00001, 5'b00001, 5'b00000, 0, 1, 5'b00000, 5'b00100, 0, 3, 1, 0);
    add("D_bub1",  0, 5'b00001, 5'b00001, 5'b00000, 0, 1, 5'b00000, 5'b00100, 0, 3, 1, 0);
    add("D_f2",    0, 5'b00101, 5'b00001, 5'b00100, 0, 1, 5'b00100, 5'b00100, 1, 3, 1, 0);
    add("D_idle2", 0, 5'b00001, 5'b00001, 5'b00001, 0, 1, 5'b00000, 5'b00000, 0, 2, 0, 0);
    add("D_p2",    0, 5'b00001, 5'b00001, 5'b00001, 0, 1, 5'b00001, 5'b00001, 1, 2, 1, 0);
    add("D_done",  0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 1, 0, 0);

    // E: credit overflow is sticky; return plus consume is neutral
    add("E_rst",   1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 4, 0, 0);
    add("E_cin",   0, 5'b00000, 5'b00000, 5'b00000, 1, 1, 5'b00000, 5'b00000, 0, 4, 0, 0);
    add("E_err",   0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 4, 0, 1);
    add("E_idle",  0, 5'b00001, 5'b00001, 5'b00001, 0, 1, 5'b00000, 5'b00000, 0, 4, 0, 1);
    add("E_both",  0, 5'b00001, 5'b00001, 5'b00001, 1, 1, 5'b00001, 5'b00001, 1, 4, 1, 1);
    add("E_done",  0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 4, 0, 1);

    // F: rr_ptr is 1 here; reset during the second flit must restore rr_ptr 0
    add("F_idle",  0, 5'b00100, 5'b00100, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 4, 0, 1);
    add("F_f1",    0, 5'b00100, 5'b00100, 5'b00000, 0, 1, 5'b00100, 5'b00100, 1, 4, 1, 1);
    add("F_f2rst", 1, 5'b00100, 5'b00000, 5'b00000, 0, 1, 5'b00100, 5'b00100, 1, 3, 1, 1);
    add("F_post",  0, 5'b11111, 5'b11111, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 4, 0, 0);
    add("F_own0",  0, 5'b11111, 5'b11111, 5'b00000, 0, 1, 5'b00001, 5'b00001, 1, 4, 1, 0);
    add("F_rst",   1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 4, 0, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Bounded wait: two-flit packet from South must start after exactly one idle cycle
    drive(1'b0, 5'b10000, 5'b10000, 5'b00000, 1'b0);
    waited = 0;
    got    = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (bus.valid_out) got = 1'b1;
      else begin
        waited++;
        @(posedge clk);
        #1;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL W_timeout: got no valid_out within 8 cycles, expected one");
    end else begin
      check_val("W_latency", 16'(waited), 16'd1);
      check_val("W_grant", 16'(bus.grant), 16'b10000);
    end
    drive(1'b0, 5'b10000, 5'b00000, 5'b10000, 1'b0);
    @(negedge clk);
    check_val("W_tail_grant", 16'(bus.grant), 16'b10000);
    drive(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    @(negedge clk);
    check_val("W_busy", 16'(bus.busy), 16'd0);
    check_val("W_credits", 16'(bus.credits), 16'd2);

`ifdef ALLOC_PKT_CNT_EN
    begin
      vec_t pv;
      add("P_rst", 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 4, 0, 0);
      add("P_idle", 0, 5'b01000, 5'b01000, 5'b01000, 0, 1, 5'b00000, 5'b00000, 0, 4, 0, 0);
      run_vec(vecs[vecs.size()-2]);
      run_vec(vecs[vecs.size()-1]);
      check_val("P_cnt0", bus.pkt_cnt, 16'd0);
      for (int p = 0; p < 3; p++) begin
        pv = vecs[vecs.size()-1];
        pv.tag = $sformatf("P_x%0d", p); pv.cin = 1'b1;
        pv.grant = 5'b01000; pv.xsel = 5'b01000; pv.valid = 1'b1; pv.busy = 1'b1;
        run_vec(pv);
        if (p < 2) begin
          pv = vecs[vecs.size()-1];
          pv.tag = $sformatf("P_idle%0d", p + 1);
          run_vec(pv);
        end
      end
      pv = vecs[vecs.size()-1];
      pv.tag = "P_done"; pv.req = '0; pv.head = '0; pv.tail = '0;
      run_vec(pv);
      check_val("P_cnt3", bus.pkt_cnt, 16'd3);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1);
  end

endmodule
